// File: rtl/cfg_ro_readback.sv
// Read-only config-space readback for two functions, with per-field 64-bit shadows.
// Latency: request accepted in cycle N gives rsp_valid in cycle N+2.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until rsp_ready.
//
// Ports: clock/reset (async active-high); req_valid/req_ready/req_func/req_addr request side;
// rsp_valid/rsp_ready/rsp_data/rsp_err response side; rd_count/err_count saturating counters;
// fN_ro_* read-only field inputs for function 0 and function 1.
module cfg_ro_readback #(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_func,
    input  logic [11:0]      req_addr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] rd_count,
    output logic [7:0]       err_count,
    input  logic [63:0]      f0_ro_csh_mmio_bar0_size,
    input  logic [63:0]      f0_ro_csh_mmio_bar1_size,
    input  logic [63:0]      f0_ro_csh_mmio_bar2_size,
    input  logic             f0_ro_csh_mmio_bar0_prefetchable,
    input  logic             f0_ro_csh_mmio_bar1_prefetchable,
    input  logic             f0_ro_csh_mmio_bar2_prefetchable,
    input  logic [31:0]      f0_ro_csh_expansion_rom_bar,
    input  logic [15:0]      f0_ro_csh_subsystem_id,
    input  logic [15:0]      f0_ro_csh_subsystem_vendor_id,
    input  logic [63:0]      f1_ro_csh_mmio_bar0_size,
    input  logic [63:0]      f1_ro_csh_mmio_bar1_size,
    input  logic [63:0]      f1_ro_csh_mmio_bar2_size,
    input  logic             f1_ro_csh_mmio_bar0_prefetchable,
    input  logic             f1_ro_csh_mmio_bar1_prefetchable,
    input  logic             f1_ro_csh_mmio_bar2_prefetchable,
    input  logic [31:0]      f1_ro_csh_expansion_rom_bar,
    input  logic [15:0]      f1_ro_csh_subsystem_id,
    input  logic [15:0]      f1_ro_csh_subsystem_vendor_id,
    input  logic [7:0]       f0_ro_otl0_tl_major_vers_capbl,
    input  logic [7:0]       f0_ro_otl0_tl_minor_vers_capbl,
    input  logic [63:0]      f0_ro_dsn_serial_number,
    input  logic [4:0]       f1_ro_pasid_max_pasid_width,
    input  logic [7:0]       f1_ro_ofunc_reset_duration,
    input  logic             f1_ro_ofunc_afu_present,
    input  logic [4:0]       f1_ro_ofunc_max_afu_index,
    input  logic [7:0]       f1_ro_octrl00_reset_duration,
    input  logic [5:0]       f1_ro_octrl00_afu_control_index,
    input  logic [4:0]       f1_ro_octrl00_pasid_len_supported,
    input  logic             f1_ro_octrl00_metadata_supported,
    input  logic [11:0]      f1_ro_octrl00_actag_len_supported
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

    state_t      state_q, state_d;
    logic        func_q;
    logic [11:0] addr_q;

    // Shadow slots: 0..2 = f0 bar0..2, 3..5 = f1 bar0..2, 6 = f0 serial number.
    logic [63:0] shadow [7];
    logic [6:0]  shadow_vld;

    logic        accept, consume;
    logic [63:0] bar_sel [3];
    logic [2:0]  pf_sel;
    logic [31:0] rom_sel;
    logic [31:0] id_sel;
    logic [31:0] lk_data;
    logic        lk_hit, lk_err, is_wide, cap_en;
    logic [2:0]  sh_idx, bar_base;
    logic [63:0] field;

    assign accept  = req_valid && req_ready;
    assign consume = rsp_valid && rsp_ready;

    // Two-process FSM: state register plus next-state/handshake decode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = LOOKUP;
            end
            LOOKUP: state_d = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Per-function field selection from the registered function bit.
    always_comb begin
        bar_sel[0] = func_q ? f1_ro_csh_mmio_bar0_size : f0_ro_csh_mmio_bar0_size;
        bar_sel[1] = func_q ? f1_ro_csh_mmio_bar1_size : f0_ro_csh_mmio_bar1_size;
        bar_sel[2] = func_q ? f1_ro_csh_mmio_bar2_size : f0_ro_csh_mmio_bar2_size;
        pf_sel     = func_q ? {f1_ro_csh_mmio_bar2_prefetchable, f1_ro_csh_mmio_bar1_prefetchable,
                               f1_ro_csh_mmio_bar0_prefetchable}
                            : {f0_ro_csh_mmio_bar2_prefetchable, f0_ro_csh_mmio_bar1_prefetchable,
                               f0_ro_csh_mmio_bar0_prefetchable};
        rom_sel    = func_q ? f1_ro_csh_expansion_rom_bar : f0_ro_csh_expansion_rom_bar;
        id_sel     = func_q ? {f1_ro_csh_subsystem_id, f1_ro_csh_subsystem_vendor_id}
                            : {f0_ro_csh_subsystem_id, f0_ro_csh_subsystem_vendor_id};
        bar_base   = func_q ? 3'd3 : 3'd0;
    end

    // Address decode. 64-bit fields occupy a dword pair: even dword = low half (captures
    // the whole field into its shadow), odd dword = high half (served from the shadow).
    always_comb begin
        lk_data = 32'h0;
        lk_hit  = 1'b0;
        is_wide = 1'b0;
        sh_idx  = 3'd0;
        field   = 64'h0;
        case (addr_q[11:2])
            10'h000: begin lk_hit = 1'b1; lk_data = id_sel; end
            10'h001: begin lk_hit = 1'b1; lk_data = rom_sel; end
            10'h002, 10'h003: begin
                lk_hit = 1'b1; is_wide = 1'b1; sh_idx = bar_base;        field = bar_sel[0];
            end
            10'h004, 10'h005: begin
                lk_hit = 1'b1; is_wide = 1'b1; sh_idx = bar_base + 3'd1; field = bar_sel[1];
            end
            10'h006, 10'h007: begin
                lk_hit = 1'b1; is_wide = 1'b1; sh_idx = bar_base + 3'd2; field = bar_sel[2];
            end
            10'h008: begin lk_hit = 1'b1; lk_data = {29'b0, pf_sel}; end
            10'h009: if (!func_q) begin
                lk_hit  = 1'b1;
                lk_data = {16'b0, f0_ro_otl0_tl_major_vers_capbl, f0_ro_otl0_tl_minor_vers_capbl};
            end
            10'h00A, 10'h00B: if (!func_q) begin
                lk_hit = 1'b1; is_wide = 1'b1; sh_idx = 3'd6; field = f0_ro_dsn_serial_number;
            end
            10'h00C: if (func_q) begin
                lk_hit  = 1'b1;
                lk_data = {3'b0, f1_ro_ofunc_max_afu_index, 7'b0, f1_ro_ofunc_afu_present,
                           f1_ro_ofunc_reset_duration, 3'b0, f1_ro_pasid_max_pasid_width};
            end
            10'h00D: if (func_q) begin
                lk_hit  = 1'b1;
                lk_data = {7'b0, f1_ro_octrl00_metadata_supported, 3'b0,
                           f1_ro_octrl00_pasid_len_supported, 2'b0,
                           f1_ro_octrl00_afu_control_index, f1_ro_octrl00_reset_duration};
            end
            10'h00E: if (func_q) begin
                lk_hit = 1'b1; lk_data = {20'b0, f1_ro_octrl00_actag_len_supported};
            end
            default: lk_hit = 1'b0;
        endcase
        if (is_wide) begin
            if (!addr_q[2])              lk_data = field[31:0];
            else if (shadow_vld[sh_idx]) lk_data = shadow[sh_idx][63:32];
            else                         lk_data = field[63:32];
        end
    end

    assign lk_err = !lk_hit || (addr_q[1:0] != 2'b00);
    assign cap_en = (state_q == LOOKUP) && is_wide && !addr_q[2] && !lk_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            func_q     <= 1'b0;
            addr_q     <= 12'h0;
            rsp_data   <= 32'h0;
            rsp_err    <= 1'b0;
            rd_count   <= '0;
            err_count  <= 8'h0;
            shadow_vld <= 7'h0;
            for (int i = 0; i < 7; i++) shadow[i] <= 64'h0;
        end else begin
            if (accept) begin
                func_q <= req_func;
                addr_q <= req_addr;
                if (rd_count != {CNT_W{1'b1}}) rd_count <= rd_count + 1'b1;
            end
            // Response registers load only in LOOKUP, so they stay frozen throughout RESP.
            if (state_q == LOOKUP) begin
                rsp_data <= lk_err ? ERR_DATA : lk_data;
                rsp_err  <= lk_err;
            end
            if (cap_en) begin
                shadow[sh_idx]     <= field;
                shadow_vld[sh_idx] <= 1'b1;
            end
            if (consume && rsp_err && (err_count != 8'hFF)) err_count <= err_count + 8'h1;
        end
    end

endmodule

// File: doc/cfg_ro_readback.md
CFG_RO_READBACK -- requirements
Module: cfg_ro_readback

Interface
REQ-001 SHALL have parameter CNT_W, default 16, setting the width of the read counter.
REQ-002 SHALL have parameter ERR_DATA, default 32'h0000_0000, giving the data returned on an error response.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  read request present.
REQ-006 req_ready  output  1  request accepted when req_valid&req_ready.
REQ-007 req_func  input  1  0=function 0, 1=function 1.
REQ-008 req_addr  input  12  byte offset; dword aligned when legal.
REQ-009 rsp_valid  output  1  response present.
REQ-010 rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
REQ-011 rsp_data  output  32  read data.
REQ-012 rsp_err  output  1  unmapped or misaligned access.
REQ-013 rd_count  output  CNT_W  saturating count of accepted requests.
REQ-014 err_count  output  8  saturating count of error responses.
REQ-015 fN_ro_csh_mmio_bar{0,1,2}_size  input  64 each  (N=0,1).
REQ-016 fN_ro_csh_mmio_bar{0,1,2}_prefetchable  input  1 each  (N=0,1).
REQ-017 fN_ro_csh_expansion_rom_bar  input  32; fN_ro_csh_subsystem_id, fN_ro_csh_subsystem_vendor_id  input  16 each  (N=0,1).
REQ-018 f0_ro_otl0_tl_major_vers_capbl, f0_ro_otl0_tl_minor_vers_capbl  input  8 each; f0_ro_dsn_serial_number  input  64.
REQ-019 f1_ro_pasid_max_pasid_width 5, f1_ro_ofunc_reset_duration 8, f1_ro_ofunc_afu_present 1, f1_ro_ofunc_max_afu_index 5, f1_ro_octrl00_reset_duration 8, f1_ro_octrl00_afu_control_index 6, f1_ro_octrl00_pasid_len_supported 5, f1_ro_octrl00_metadata_supported 1, f1_ro_octrl00_actag_len_supported 12  all inputs.

Function
REQ-020 Map, both functions: 0x000={subsystem_id,subsystem_vendor_id}; 0x004=expansion_rom_bar; 0x008/0x00C=bar0_size lo/hi; 0x010/0x014=bar1; 0x018/0x01C=bar2; 0x020={29'b0,bar2_pf,bar1_pf,bar0_pf}.
REQ-021 Function 0 only: 0x024={16'b0,major,minor}; 0x028/0x02C=serial_number lo/hi.
REQ-022 Function 1 only: 0x030={3'b0,max_afu_index,7'b0,afu_present,ofunc_reset_duration,3'b0,max_pasid_width}; 0x034={7'b0,metadata,3'b0,pasid_len,2'b0,afu_control_index,octrl00_reset_duration}; 0x038={20'b0,actag_len}.
REQ-023 Any other offset, a function-specific offset on the wrong function, or req_addr[1:0]!=0 SHALL respond rsp_err=1, rsp_data=ERR_DATA.
REQ-024 FSM states IDLE, LOOKUP, RESP; IDLE->LOOKUP on accept, LOOKUP->RESP unconditionally, RESP->IDLE on rsp_ready.
REQ-025 req_ready=1 only in IDLE; request fields registered on accept.
REQ-026 Accept in cycle N gives rsp_valid=1 in cycle N+2 (fixed 2-cycle latency).
REQ-027 Read of a 64-bit high dword (0x00C/0x014/0x01C/0x02C) SHALL return the value captured at the most recent low-dword read of the same field and function; with no prior low read, the current input.
REQ-028 Low-dword read SHALL capture the full 64-bit field into a per-field shadow in LOOKUP.
REQ-029 rsp_valid, rsp_data, rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-030 No new request accepted in the cycle the response is consumed; earliest next accept is the following cycle.
REQ-031 rd_count increments on accept, saturates at all-ones; err_count increments on error response consumption, saturates at 8'hFF.

Reset
REQ-032 reset SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, rd_count=0, err_count=0, all shadows cleared, immediately and independent of clock.
REQ-033 reset asserted mid-transaction SHALL discard the pending request; no response after deassertion.

Verification
REQ-034 func=0, addr=0x000, vendor 16'h1014, subsystem 16'h060D -> rsp_data=32'h060D_1014, rsp_err=0, two cycles after accept.
REQ-035 func=1 read 0x008 then 0x00C, bar0_size 64'hFFFF_FFFF_FC00_0000 changed to 64'h0 between reads -> 32'hFC00_0000 then 32'hFFFF_FFFF.
REQ-036 func=0 addr=0x030; func=1 addr=0x006 -> rsp_err=1, rsp_data=ERR_DATA, err_count=2.
REQ-037 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout, no second accept.
REQ-038 reset pulsed in LOOKUP -> rsp_valid stays 0, rd_count=0, req_ready=1 after reset.
REQ-039 CNT_W=4, 17 accepted reads -> rd_count=4'hF.
